pu_feeder: RTL
==============

PU_FEEDER -- requirements
Module: pu_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: operand width in FP16 format.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: operand-pair buffer entries, power of two.
REQ-003 SHALL have parameter LEN_WIDTH, default 8: width of the dot-product length.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 3: flush cycles after the last pair.
REQ-005 SHALL have port clk  input  1  the single clock.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  request a new dot product.
REQ-008 SHALL have port len  input  LEN_WIDTH  number of operand pairs, sampled with start.
REQ-009 SHALL have ports in_valid input 1, in_ready output 1, in_a input DATA_WIDTH, in_b input DATA_WIDTH: operand-pair stream.
REQ-010 SHALL have ports pu_en output 1, pu_a output DATA_WIDTH, pu_b output DATA_WIDTH: drive the downstream MAC processing unit.
REQ-011 SHALL have port pu_clr  output  1  one-cycle accumulator-clear pulse to the PU.
REQ-012 SHALL have ports busy output 1 (not IDLE) and done output 1 (one-cycle completion pulse).

Function
REQ-013 SHALL implement states IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-014 IDLE: start=1 with len!=0 SHALL latch len and go to CLEAR; start with len=0 SHALL stay in IDLE and pulse done next cycle.
REQ-015 CLEAR SHALL last exactly one cycle with pu_clr=1, pu_en=0, then go to STREAM.
REQ-016 A pair SHALL be pushed when in_valid && in_ready.
REQ-017 in_ready SHALL be 1 only in STREAM, with FIFO not full and accepted count < latched len.
REQ-018 STREAM: when the FIFO is non-empty, the head SHALL be popped, registered onto pu_a/pu_b with pu_en=1 next cycle, and the issued count incremented.
REQ-019 With no pop, pu_en SHALL be 0 and pu_a/pu_b SHALL hold.
REQ-020 Push and pop in the same cycle SHALL leave occupancy unchanged; a push when full SHALL never occur.
REQ-021 When issued count reaches len, the state SHALL go to DRAIN.
REQ-022 DRAIN SHALL drive pu_en=1, pu_a=pu_b=16'h0000 for exactly DRAIN_CYCLES cycles, then go to DONE.
REQ-023 DONE SHALL assert done for one cycle and return to IDLE.
REQ-024 start while busy SHALL be ignored.
REQ-025 Counters SHALL be LEN_WIDTH+1 bits; len=2^LEN_WIDTH-1 SHALL complete without wrap.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, empty the FIFO, zero all counters and drive in_ready=0, pu_en=0, pu_a=0, pu_b=0, pu_clr=0, busy=0, done=0.
REQ-027 Reset mid-operation SHALL discard buffered pairs; no done SHALL follow.

Configuration
REQ-028 With PU_FEEDER_ZERO_SKIP_EN defined, a popped pair with either operand ±0 (bits[14:0]==0) SHALL be counted as issued but SHALL drive pu_en=0.
REQ-029 Without PU_FEEDER_ZERO_SKIP_EN, every popped pair SHALL drive pu_en=1.

Structure
REQ-030 Package tpu_pkg SHALL hold the state enum, FP16 zero constant and default widths.
REQ-031 The FIFO SHALL be sub-module pu_feeder_fifo (parameterised width and depth, full/empty flags).

Verification
REQ-032 start, len=2; pairs (3C00,4000), (4200,4400) -> pu_clr pulse, two pu_en cycles carrying those pairs, 3 drain cycles, done; with the PU attached, P=4B00 (14.0).
REQ-033 len=6, in_valid held high, downstream idle gaps none -> in_ready drops after 6 accepts, never while FIFO full; 6 issues then drain.
REQ-034 start with len=0 -> busy stays 0, done pulses next cycle.
REQ-035 reset_n low during STREAM after 2 of 4 pairs -> all outputs 0 immediately; new start runs cleanly with FIFO empty.
REQ-036 start asserted during DRAIN -> ignored; single done.
REQ-037 With PU_FEEDER_ZERO_SKIP_EN, len=3 with pair 2 = (0000,4000) -> two pu_en issue cycles, done still after 3 pairs + drain; without the macro -> three.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg -- shared definitions for the PU feeder slice.
//   * FSM state encoding for pu_feeder (IDLE, CLEAR, STREAM, DRAIN, DONE)
//   * FP16 zero constant used for drain operands
//   * default widths / sizes for the feeder parameters
package tpu_pkg;

  // Default configuration of the feeder.
  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_LEN_WIDTH    = 8;
  localparam int DEF_DRAIN_CYCLES = 3;

  // +0.0 in FP16; fed to the PU while draining its pipeline.
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  // Feeder state encoding (plain constants so older tools can share it).
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLEAR  = 3'd1;
  localparam state_t ST_STREAM = 3'd2;
  localparam state_t ST_DRAIN  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/pu_feeder_fifo.sv
// pu_feeder_fifo -- small synchronous FIFO holding operand pairs.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data     write one entry (ignored when full)
//   pop                 discard the head entry (ignored when empty)
//   head_data           current head entry, valid whenever !empty
//   full, empty         occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module pu_feeder_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr_reg];

  // Storage carries no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pu_feeder.sv
// pu_feeder -- buffers an FP16 operand-pair stream and feeds it to a MAC
// processing unit: clear pulse, one pu_en cycle per pair, DRAIN_CYCLES
// zero-operand flush cycles, then a one-cycle done pulse.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   start, len                     request a dot product of len pairs
//   in_valid/in_ready/in_a/in_b    operand-pair input stream
//   pu_en/pu_a/pu_b                operands to the PU (registered)
//   pu_clr                         one-cycle accumulator clear
//   busy, done                     status / completion pulse
// Build option: define PU_FEEDER_ZERO_SKIP_EN to suppress pu_en for pairs
// with a signed-zero operand (still counted as issued).
module pu_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  pu_en,
  output logic [DATA_WIDTH-1:0] pu_a,
  output logic [DATA_WIDTH-1:0] pu_b,
  output logic                  pu_clr,
  output logic                  busy,
  output logic                  done
);

  // One extra bit so len = 2^LEN_WIDTH-1 never wraps the counters.
  localparam int CW  = LEN_WIDTH + 1;
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t                state_reg, state_next;
  logic [CW-1:0]         len_reg;
  logic [CW-1:0]         acc_cnt_reg;
  logic [CW-1:0]         iss_cnt_reg;
  logic [DCW-1:0]        drain_cnt_reg;
  logic                  zlen_done_reg;
  logic                  pu_en_reg, pu_en_next;
  logic [DATA_WIDTH-1:0] pu_a_reg, pu_a_next;
  logic [DATA_WIDTH-1:0] pu_b_reg, pu_b_next;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0]   head_a, head_b;
  logic                    skip;

  assign head_a = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign head_b = fifo_head[DATA_WIDTH-1:0];

  assign in_ready  = (state_reg == ST_STREAM) && !fifo_full && (acc_cnt_reg < len_reg);
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state_reg == ST_STREAM) && !fifo_empty && (iss_cnt_reg < len_reg);

`ifdef PU_FEEDER_ZERO_SKIP_EN
  // Sign bit ignored: +0 and -0 both contribute nothing to the MAC.
  assign skip = (head_a[DATA_WIDTH-2:0] == '0) || (head_b[DATA_WIDTH-2:0] == '0);
`else
  assign skip = 1'b0;
`endif

  pu_feeder_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data ({in_a, in_b}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start && (len != '0)) state_next = ST_CLEAR;
      ST_CLEAR:  state_next = ST_STREAM;
      // Checked on the registered count so the last pair's pu_en cycle
      // completes before the first drain cycle.
      ST_STREAM: if (iss_cnt_reg == len_reg) state_next = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt_reg == DCW'(DRAIN_CYCLES - 1)) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // PU operands are registered; a pop and a drain entry never coincide
  // because pops stop once the issued count reaches len.
  always_comb begin
    pu_en_next = 1'b0;
    pu_a_next  = pu_a_reg;
    pu_b_next  = pu_b_reg;
    if (fifo_pop) begin
      pu_en_next = !skip;
      pu_a_next  = head_a;
      pu_b_next  = head_b;
    end else if (state_next == ST_DRAIN) begin
      pu_en_next = 1'b1;
      pu_a_next  = DATA_WIDTH'(FP16_ZERO);
      pu_b_next  = DATA_WIDTH'(FP16_ZERO);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      acc_cnt_reg   <= '0;
      iss_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
      zlen_done_reg <= 1'b0;
      pu_en_reg     <= 1'b0;
      pu_a_reg      <= '0;
      pu_b_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      pu_en_reg     <= pu_en_next;
      pu_a_reg      <= pu_a_next;
      pu_b_reg      <= pu_b_next;
      zlen_done_reg <= (state_reg == ST_IDLE) && start && (len == '0);
      if (state_reg == ST_IDLE) begin
        acc_cnt_reg <= '0;
        iss_cnt_reg <= '0;
        if (start) len_reg <= CW'(len);
      end else begin
        if (fifo_push) acc_cnt_reg <= acc_cnt_reg + 1'b1;
        if (fifo_pop)  iss_cnt_reg <= iss_cnt_reg + 1'b1;
      end
      if (state_reg == ST_DRAIN) drain_cnt_reg <= drain_cnt_reg + 1'b1;
      else                       drain_cnt_reg <= '0;
    end
  end

  assign pu_en  = pu_en_reg;
  assign pu_a   = pu_a_reg;
  assign pu_b   = pu_b_reg;
  assign pu_clr = (state_reg == ST_CLEAR);
  assign busy   = (state_reg != ST_IDLE);
  assign done   = (state_reg == ST_DONE) || zlen_done_reg;

endmodule
